// File: rtl/dbus_cbus_bridge.sv
// Memory-stage DBus to CBus bridge: one registered single-beat CBus transaction per accepted request.
// Optional build macro DBUS_ALIGN_CHECK_EN answers misaligned accesses locally without CBus traffic.
package dbus_cbus_pkg;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  typedef logic [7:0] mlen_t;
  localparam mlen_t MLEN1 = 8'd0;

  typedef enum logic [1:0] {
    AXI_BURST_FIXED = 2'b00,
    AXI_BURST_INCR  = 2'b01,
    AXI_BURST_WRAP  = 2'b10
  } axi_burst_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    msize_t      size;
    logic [63:0] addr;
    logic [7:0]  strobe;
    logic [63:0] data;
    mlen_t       len;
    axi_burst_t  burst;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;

endpackage

module dbus_cbus_bridge
  import dbus_cbus_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  dbus_req_t        dreq,
  output dbus_resp_t       dresp,
  output cbus_req_t        creq,
  input  cbus_resp_t       cresp,
  output logic [CNT_W-1:0] wait_cnt,
  output logic             misalign
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [63:0]      r_addr;
  msize_t           r_size;
  logic [7:0]       r_strobe;
  logic [63:0]      r_wdata;
  logic [63:0]      r_rdata;
  logic             r_creq_valid;
  logic             r_data_ok;
  logic             r_misalign;
  logic [CNT_W-1:0] r_wait_cnt;
  logic             w_misaligned;

  // NOTE: combinational blocks assign a default first so no path leaves a signal unassigned (no latch).
  always_comb begin
    w_misaligned = 1'b0;
`ifdef DBUS_ALIGN_CHECK_EN
    case (dreq.size)
      MSIZE2:  w_misaligned = dreq.addr[0];
      MSIZE4:  w_misaligned = |dreq.addr[1:0];
      MSIZE8:  w_misaligned = |dreq.addr[2:0];
      default: w_misaligned = 1'b0;
    endcase
`endif
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the latched request is reset too, so the bus never sees stale X fields after reset.
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_size       <= MSIZE1;
      r_strobe     <= '0;
      r_wdata      <= '0;
      r_rdata      <= '0;
      r_creq_valid <= 1'b0;
      r_data_ok    <= 1'b0;
      r_misalign   <= 1'b0;
      r_wait_cnt   <= '0;
    end else begin
      r_data_ok  <= 1'b0;
      r_misalign <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (dreq.valid) begin
            r_addr   <= dreq.addr;
            r_size   <= dreq.size;
            r_strobe <= dreq.strobe;
            r_wdata  <= dreq.data;
            if (w_misaligned) begin
              r_state    <= S_DONE;
              r_rdata    <= '0;
              r_data_ok  <= 1'b1;
              r_misalign <= 1'b1;
            end else begin
              r_state      <= S_REQ;
              r_creq_valid <= 1'b1;
            end
          end
        end
        S_REQ: begin
          if (r_wait_cnt != '1) begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
          end
          if (cresp.ready && cresp.last) begin
            r_state      <= S_DONE;
            r_rdata      <= cresp.data;
            r_creq_valid <= 1'b0;
            r_data_ok    <= 1'b1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // addr_ok is the only combinational response; it is forced low while reset is held.
  always_comb begin
    dresp         = '0;
    dresp.addr_ok = reset && (r_state == S_IDLE) && dreq.valid;
    dresp.data_ok = r_data_ok;
    dresp.data    = r_rdata;
  end

  always_comb begin
    creq          = '0;
    creq.valid    = r_creq_valid;
    creq.is_write = |r_strobe;
    creq.size     = r_size;
    creq.addr     = r_addr;
    creq.strobe   = r_strobe;
    creq.data     = r_wdata;
    creq.len      = MLEN1;
    creq.burst    = AXI_BURST_FIXED;
  end

  assign wait_cnt = r_wait_cnt;
  assign misalign = r_misalign;

  // A beat without last would be a multi-beat reply to a single-beat request.
  a_ready_implies_last: assert property (@(posedge clk) disable iff (!reset)
    (r_state == S_REQ && cresp.ready) |-> cresp.last);

endmodule

// File: tb/tb_dbus_cbus_bridge.sv
// Bench for dbus_cbus_bridge: transaction-timeline model, per-cycle compare, directed and random traffic.
module tb_dbus_cbus_bridge;
  import dbus_cbus_pkg::*;

  localparam int CNT_W = 32;
`ifdef DBUS_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  dbus_req_t        dreq;
  dbus_resp_t       dresp;
  cbus_req_t        creq;
  cbus_resp_t       cresp;
  logic [CNT_W-1:0] wait_cnt;
  logic             misalign;

  dbus_cbus_bridge #(.CNT_W(CNT_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .dreq     (dreq),
    .dresp    (dresp),
    .creq     (creq),
    .cresp    (cresp),
    .wait_cnt (wait_cnt),
    .misalign (misalign)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected outputs for the current cycle, set by the stimulus from the transaction timeline.
  bit              chk_en = 1'b0;
  bit              e_addr_ok, e_creq_valid, e_data_ok, e_misalign;
  logic [63:0]     e_data;
  dbus_req_t       e_req;
  longint unsigned e_wait = 0;
  int              n_exp_bus = 0;
  int              n_exp_dok = 0;

  // Observations gathered by the compare process.
  int          cyc = 0;
  int          data_ok_cyc = -1;
  int          accept_cyc = 0;
  int          n_bus = 0;
  int          n_dok = 0;
  bit          prev_valid = 1'b0;
  logic [63:0] last_rdata;
  logic        last_is_write;
  logic [7:0]  last_strobe;
  logic [63:0] last_caddr;

  function automatic longint unsigned sat_wait(input longint unsigned v);
    longint unsigned max_v;
    max_v = (longint'(1) << CNT_W) - 1;
    return (v > max_v) ? max_v : v;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("addr_ok", dresp.addr_ok, e_addr_ok);
      check("creq_valid", creq.valid, e_creq_valid);
      if (e_creq_valid) begin
        check("creq_addr", creq.addr, e_req.addr);
        check("creq_size", creq.size, e_req.size);
        check("creq_strobe", creq.strobe, e_req.strobe);
        check("creq_data", creq.data, e_req.data);
        check("creq_is_write", creq.is_write, e_req.strobe != 8'h00);
        check("creq_len", creq.len, MLEN1);
        check("creq_burst", creq.burst, AXI_BURST_FIXED);
        last_is_write = creq.is_write;
        last_strobe   = creq.strobe;
        last_caddr    = creq.addr;
      end
      check("data_ok", dresp.data_ok, e_data_ok);
      if (e_data_ok) check("rdata", dresp.data, e_data);
      check("misalign", misalign, e_misalign);
      check("wait_cnt", wait_cnt, sat_wait(e_wait));
      if (creq.valid && !prev_valid) n_bus++;
      prev_valid = creq.valid;
      if (dresp.data_ok) begin
        n_dok++;
        data_ok_cyc = cyc;
        last_rdata  = dresp.data;
      end
    end else begin
      prev_valid = 1'b0;
    end
  end

  function automatic bit misaligned_f(input msize_t s, input logic [63:0] a);
    longint unsigned bytes, ua;
    bytes = longint'(1) << int'(s);
    ua    = a;
    return (ua % bytes) != 0;
  endfunction

  function automatic dbus_req_t rand_req();
    dbus_req_t r;
    r.valid  = 1'b1;
    r.addr   = {$urandom, $urandom};
    if ($urandom_range(0, 1) == 1) r.addr[2:0] = 3'b000;
    r.size   = msize_t'($urandom_range(0, 3));
    r.strobe = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'h00;
    r.data   = {$urandom, $urandom};
    return r;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_idle_exp();
    e_addr_ok    = 1'b0;
    e_creq_valid = 1'b0;
    e_data_ok    = 1'b0;
    e_misalign   = 1'b0;
  endtask

  task automatic quiet_bus();
    cresp.ready = 1'b0;
    cresp.last  = 1'b0;
    cresp.data  = {$urandom, $urandom};
  endtask

  task automatic idle_cycle();
    dreq       = rand_req();
    dreq.valid = 1'b0;
    quiet_bus();
    set_idle_exp();
    next_cycle();
  endtask

  // Accept cycle, (waits+1) bus cycles unless answered locally, then one data_ok cycle.
  task automatic run_txn(input dbus_req_t r, input int waits, input logic [63:0] rd);
    bit mis;
    mis        = ALIGN_EN && misaligned_f(r.size, r.addr);
    r.valid    = 1'b1;
    dreq       = r;
    quiet_bus();
    set_idle_exp();
    e_addr_ok  = 1'b1;
    e_req      = r;
    accept_cyc = cyc;
    next_cycle();
    if (!mis) begin
      n_exp_bus++;
      for (int k = 0; k <= waits; k++) begin
        dreq = rand_req();
        quiet_bus();
        if (k == waits) begin
          cresp.ready = 1'b1;
          cresp.last  = 1'b1;
          cresp.data  = rd;
        end
        set_idle_exp();
        e_creq_valid = 1'b1;
        next_cycle();
        e_wait++;
      end
    end
    dreq = r;
    quiet_bus();
    set_idle_exp();
    e_data_ok  = 1'b1;
    e_data     = mis ? 64'h0 : rd;
    e_misalign = mis;
    n_exp_dok++;
    next_cycle();
  endtask

  initial begin
    dbus_req_t r;
    int        b0, d0;

    reset = 1'b0;
    dreq  = rand_req();
    quiet_bus();
    set_idle_exp();
    repeat (2) @(posedge clk);
    #1;
    check("por_creq_valid", creq.valid, 0);
    check("por_addr_ok", dresp.addr_ok, 0);
    check("por_data_ok", dresp.data_ok, 0);
    check("por_data", dresp.data, 0);
    check("por_wait_cnt", wait_cnt, 0);
    check("por_misalign", misalign, 0);
    reset  = 1'b1;
    e_wait = 0;
    chk_en = 1'b1;
    idle_cycle();
    idle_cycle();

    // Load, bus beat after two wait cycles.
    r = '0;
    r.addr = 64'h8000_0010; r.size = MSIZE8; r.strobe = 8'h00; r.data = 64'h0;
    run_txn(r, 2, 64'hDEAD_BEEF_0123_4567);
    check("t2_is_write", last_is_write, 0);
    check("t2_rdata", last_rdata, 64'hDEAD_BEEF_0123_4567);
    check("t2_wait_cnt", wait_cnt, 3);
    idle_cycle();

    // Store with immediate ready: data_ok in the third cycle counting the valid cycle.
    r = '0;
    r.addr = 64'h8000_0004; r.size = MSIZE4; r.strobe = 8'hF0; r.data = 64'h1122_3344_0000_0000;
    run_txn(r, 0, 64'h0);
    check("t3_is_write", last_is_write, 1);
    check("t3_strobe", last_strobe, 8'hF0);
    check("t3_latency", 64'(data_ok_cyc - accept_cyc), 2);
    idle_cycle();

    // Back-to-back load then store, dreq.valid held through each DONE cycle.
    b0 = n_bus;
    d0 = n_dok;
    r = '0;
    r.addr = 64'h8000_0100; r.size = MSIZE8; r.strobe = 8'h00;
    run_txn(r, 1, 64'hA5A5_5A5A_0F0F_F0F0);
    r.addr = 64'h8000_0108; r.strobe = 8'hFF; r.data = 64'h0123_4567_89AB_CDEF;
    run_txn(r, 0, 64'h0);
    idle_cycle();
    idle_cycle();
    check("t4_bus_txns", 64'(n_bus - b0), 2);
    check("t4_data_oks", 64'(n_dok - d0), 2);
    check("t4_store_addr", last_caddr, 64'h8000_0108);

    // Reset in the middle of a bus wait; the accepted address is perturbed on dreq meanwhile.
    r = rand_req();
    r.addr[2:0] = 3'b000;
    r.size = MSIZE8;
    dreq = r; quiet_bus(); set_idle_exp(); e_addr_ok = 1'b1; e_req = r;
    next_cycle();
    dreq.addr = ~r.addr;
    quiet_bus(); set_idle_exp(); e_creq_valid = 1'b1; n_exp_bus++;
    next_cycle();
    e_wait++;
    quiet_bus(); set_idle_exp(); e_creq_valid = 1'b1;
    #2;
    chk_en = 1'b0;
    reset  = 1'b0;
    #1;
    check("rst_creq_valid", creq.valid, 0);
    check("rst_addr_ok", dresp.addr_ok, 0);
    check("rst_data_ok", dresp.data_ok, 0);
    check("rst_data", dresp.data, 0);
    check("rst_wait_cnt", wait_cnt, 0);
    check("rst_misalign", misalign, 0);
    dreq.valid = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
    reset  = 1'b1;
    e_wait = 0;
    chk_en = 1'b1;
    idle_cycle();

    // Word load at a half-word address: answered locally only with the alignment check built in.
    r = '0;
    r.addr = 64'h8000_0002; r.size = MSIZE4;
    b0 = n_bus;
    run_txn(r, 0, 64'h7777_6666_5555_4444);
    check("t6_latency", 64'(data_ok_cyc - accept_cyc), ALIGN_EN ? 1 : 2);
    check("t6_bus_txns", 64'(n_bus - b0), ALIGN_EN ? 0 : 1);
    check("t6_rdata", last_rdata, ALIGN_EN ? 64'h0 : 64'h7777_6666_5555_4444);
    idle_cycle();

    for (int i = 0; i < 150; i++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) idle_cycle();
      run_txn(rand_req(), $urandom_range(0, 4), {$urandom, $urandom});
    end
    idle_cycle();
    idle_cycle();

    check("total_bus_txns", 64'(n_bus), 64'(n_exp_bus));
    check("total_data_oks", 64'(n_dok), 64'(n_exp_dok));

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
